// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: B response codes and the 2-entry skid buffer state encoding.
package axi_node_pkg;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_EXOKAY = 2'b01;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;
   localparam logic [1:0] BRESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/axi_b_response_router_if.sv
// B channel bundle of the response router: one master-side link in, N per-port links out.
interface axi_b_response_router_if #(
   parameter int AXI_USER_W  = 6,
   parameter int N_TARG_PORT = 7,
   parameter int AXI_ID_IN   = 16,
   parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
   parameter int AXI_ID_OUT  = AXI_ID_IN + LOG_N_TARG
);
   logic [AXI_ID_OUT-1:0]             bid_i;
   logic [1:0]                        bresp_i;
   logic [AXI_USER_W-1:0]             buser_i;
   logic                              bvalid_i;
   logic                              bready_o;
   logic [N_TARG_PORT*AXI_ID_IN-1:0]  bid_o;
   logic [N_TARG_PORT*2-1:0]          bresp_o;
   logic [N_TARG_PORT*AXI_USER_W-1:0] buser_o;
   logic [N_TARG_PORT-1:0]            bvalid_o;
   logic [N_TARG_PORT-1:0]            bready_i;

   modport slave (
      input  bid_i, bresp_i, buser_i, bvalid_i, bready_i,
      output bready_o, bid_o, bresp_o, buser_o, bvalid_o
   );

   modport master (
      output bid_i, bresp_i, buser_i, bvalid_i, bready_i,
      input  bready_o, bid_o, bresp_o, buser_o, bvalid_o
   );
endinterface

// File: rtl/axi_b_skid_buffer.sv
// Generic 2-entry valid/ready register slice; in_ready depends only on the state register.
module axi_b_skid_buffer
   import axi_node_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);
   skid_state_e       state_q, state_d;
   logic [DATA_W-1:0] entry_p0, entry_p1;
   logic              enq, deq;

   assign in_ready  = (state_q != SKID_TWO);
   assign out_valid = (state_q != SKID_EMPTY);
   assign out_data  = entry_p0;
   assign enq       = in_valid && in_ready;
   assign deq       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= SKID_EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SKID_EMPTY: if (enq) state_d = SKID_ONE;
         SKID_ONE: begin
            if (enq && !deq)      state_d = SKID_TWO;
            else if (!enq && deq) state_d = SKID_EMPTY;
         end
         SKID_TWO:   if (deq) state_d = SKID_ONE;
         default:    state_d = SKID_EMPTY;
      endcase
   end

   // entry_p0 is the head, entry_p1 the overflow slot; payload needs no reset
   always_ff @(posedge clk) begin
      case (state_q)
         SKID_EMPTY: if (enq) entry_p0 <= in_data;
         SKID_ONE: begin
            if (enq && deq) entry_p0 <= in_data;
            else if (enq)   entry_p1 <= in_data;
         end
         SKID_TWO:   if (deq) entry_p0 <= entry_p1;
         default: ;
      endcase
   end
endmodule

// File: rtl/axi_b_response_router.sv
// Routes master-side B responses to their target port by ID prefix, tracking outstanding writes per port.
module axi_b_response_router
   import axi_node_pkg::*;
#(
   parameter int AXI_USER_W  = 6,
   parameter int N_TARG_PORT = 7,
   parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
   parameter int AXI_ID_IN   = 16,
   parameter int AXI_ID_OUT  = AXI_ID_IN + LOG_N_TARG,
   parameter int OUTST_W     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   axi_b_response_router_if.slave b,
   input  logic                   aw_push_i,
   input  logic [LOG_N_TARG-1:0]  aw_port_i,
   output logic [N_TARG_PORT-1:0] aw_stall_o,
   output logic                   err_o,
   output logic [AXI_ID_OUT-1:0]  err_id_o,
   output logic                   idle_o
);
   typedef struct packed {
      logic [LOG_N_TARG-1:0] port;
      logic [AXI_ID_IN-1:0]  id;
      logic [1:0]            resp;
      logic [AXI_USER_W-1:0] user;
   } b_entry_t;

   localparam int                 ENTRY_W = $bits(b_entry_t);
   localparam logic [OUTST_W-1:0] CNT_MAX = '1;

   logic [LOG_N_TARG-1:0]  in_port;
   logic                   port_ok, stray, accept, skid_ready;
   logic [N_TARG_PORT-1:0] cnt_nz;
   b_entry_t               in_entry, head;
   logic [ENTRY_W-1:0]     head_bits;
   logic                   head_vld, head_ready;

   assign in_port  = b.bid_i[AXI_ID_OUT-1:AXI_ID_IN];
   assign port_ok  = {1'b0, in_port} < (LOG_N_TARG+1)'(N_TARG_PORT);
   assign stray    = !port_ok || !cnt_nz[in_port];
   assign accept   = b.bvalid_i && skid_ready;
   assign b.bready_o = skid_ready;

   assign in_entry = '{port: in_port, id: b.bid_i[AXI_ID_IN-1:0],
                       resp: b.bresp_i, user: b.buser_i};

   axi_b_skid_buffer #(.DATA_W(ENTRY_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_entry),
      .in_valid  (b.bvalid_i && !stray),
      .in_ready  (skid_ready),
      .out_data  (head_bits),
      .out_valid (head_vld),
      .out_ready (head_ready)
   );

   assign head       = b_entry_t'(head_bits);
   assign head_ready = b.bready_i[head.port];
   assign idle_o     = !head_vld && (cnt_nz == '0);

   for (genvar p = 0; p < N_TARG_PORT; p++) begin : g_port
      logic [OUTST_W-1:0] cnt_q;
      logic               inc, dec;

      assign inc = aw_push_i && (aw_port_i == LOG_N_TARG'(p));
      assign dec = accept && !stray && (in_port == LOG_N_TARG'(p));

      // Coincident push and pop cancel even when saturated
      always_ff @(posedge clk or posedge rst) begin
         if (rst)                                   cnt_q <= '0;
         else if (inc && !dec && cnt_q != CNT_MAX)  cnt_q <= cnt_q + 1'b1;
         else if (dec && !inc)                      cnt_q <= cnt_q - 1'b1;
      end

      assign cnt_nz[p]     = (cnt_q != '0);
      assign aw_stall_o[p] = (cnt_q == CNT_MAX);

      // Payload is gated by head valid so an empty buffer presents zeros
      assign b.bvalid_o[p]                           = head_vld && (head.port == LOG_N_TARG'(p));
      assign b.bid_o[p*AXI_ID_IN +: AXI_ID_IN]       = head_vld ? head.id   : '0;
      assign b.bresp_o[p*2 +: 2]                     = head_vld ? head.resp : '0;
      assign b.buser_o[p*AXI_USER_W +: AXI_USER_W]   = head_vld ? head.user : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_o    <= 1'b0;
         err_id_o <= '0;
      end else begin
         err_o <= accept && stray;
         if (accept && stray) err_id_o <= b.bid_i;
      end
   end
endmodule
